// File: rtl/sound_fx_player.sv
// sound_fx_player: prioritised square-wave sound effects on the buzzer pin.
// Define SOUND_FX_QUEUE_EN to add a 1-entry pending request slot.
module sound_fx_player #(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_FX  = 4,
  parameter int HP_W    = 17
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NUM_FX-1:0] fx_req,
  input  logic              mute,
  output logic [NUM_FX-1:0] fx_ack,
  output logic              busy,
  output logic [1:0]        fx_active,
  output logic              buzzer
);

  localparam int TDIV = CLK_HZ / TICK_HZ;
  localparam int PS_W = (TDIV > 1) ? $clog2(TDIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t            state, state_n;
  logic [1:0]        note;
  logic [HP_W-1:0]   hp_q, hp_cnt, cur_hp;
  logic [7:0]        dur_q, tk_cnt, cur_dur, nxt_dur;
  logic [PS_W-1:0]   ps_cnt;
  logic              tone;
  logic              tick, note_end, has_next, last;
  logic              any_req, accept, pend_go;
  logic [1:0]        win;
  logic [NUM_FX-1:0] ack_n, q_ack;
  logic              pend_v;
  logic [1:0]        pend_idx;

  function automatic logic [HP_W-1:0] hp_of(input int f);
    return (f == 0) ? '0 : HP_W'(CLK_HZ / (2 * f));
  endfunction

  function automatic logic [HP_W-1:0] hp_rom(
    input logic [1:0] fx,
    input logic [1:0] n
  );
    logic [HP_W-1:0] h;
    case ({fx, n})
      4'b0000: h = hp_of(200);
      4'b0001: h = hp_of(150);
      4'b0010: h = hp_of(100);
      4'b0100: h = hp_of(800);
      4'b0101: h = hp_of(400);
      4'b1000: h = hp_of(1500);
      4'b1100: h = hp_of(1000);
      4'b1110: h = hp_of(1000);
      default: h = '0;
    endcase
    return h;
  endfunction

  function automatic logic [7:0] dur_rom(
    input logic [1:0] fx,
    input logic [1:0] n
  );
    logic [7:0] d;
    case ({fx, n})
      4'b0000: d = 8'd100;
      4'b0001: d = 8'd100;
      4'b0010: d = 8'd200;
      4'b0100: d = 8'd30;
      4'b0101: d = 8'd30;
      4'b1000: d = 8'd20;
      4'b1100: d = 8'd50;
      4'b1101: d = 8'd20;
      4'b1110: d = 8'd50;
      4'b1111: d = 8'd20;
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  // Effect ROM lookups and end-of-note detection
  always_comb begin
    cur_hp   = hp_rom(fx_active, note);
    cur_dur  = dur_rom(fx_active, note);
    nxt_dur  = dur_rom(fx_active, note + 2'd1);
    tick     = (ps_cnt == PS_W'(TDIV - 1));
    note_end = (state == PLAY) && tick &&
               (tk_cnt == dur_q - 8'd1);
    has_next = (note != 2'd3) && (nxt_dur != 8'd0);
    last     = note_end && !has_next;
  end

  // Lowest set request wins; accept when idle or outranking
  always_comb begin
    win = '0;
    for (int i = NUM_FX - 1; i >= 0; i--)
      if (fx_req[i]) win = 2'(i);
    any_req = |fx_req;
    accept  = any_req &&
              (state == IDLE || last || win <= fx_active);
    pend_go = last && pend_v && !accept;
    ack_n   = '0;
    if (accept) ack_n[win] = 1'b1;
  end

`ifdef SOUND_FX_QUEUE_EN
  logic       cand, take;
  logic [1:0] cand_idx;

  // Pick the request competing for the pending slot
  always_comb begin
    cand     = 1'b0;
    cand_idx = '0;
    if (accept) begin
      for (int i = NUM_FX - 1; i >= 0; i--)
        if (fx_req[i] && 2'(i) != win) begin
          cand     = 1'b1;
          cand_idx = 2'(i);
        end
    end else if (any_req) begin
      cand     = 1'b1;
      cand_idx = win;
    end
    take  = cand && (!pend_v || cand_idx < pend_idx);
    q_ack = '0;
    if (take) q_ack[cand_idx] = 1'b1;
  end

  // Pending slot: filled on take, emptied when it starts
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_v   <= 1'b0;
      pend_idx <= '0;
    end else if (take) begin
      pend_v   <= 1'b1;
      pend_idx <= cand_idx;
    end else if (pend_go) begin
      pend_v   <= 1'b0;
    end
  end
`else
  assign pend_v   = 1'b0;
  assign pend_idx = '0;
  assign q_ack    = '0;
`endif

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = IDLE;
      LOAD:    state_n = PLAY;
      PLAY:    if (note_end) state_n = has_next ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
    if (accept || pend_go) state_n = LOAD;
  end

  // State, effect selection, note index and ack pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      fx_active <= '0;
      note      <= '0;
      fx_ack    <= '0;
    end else begin
      state  <= state_n;
      fx_ack <= ack_n | q_ack;
      if (accept) begin
        fx_active <= win;
        note      <= '0;
      end else if (pend_go) begin
        fx_active <= pend_idx;
        note      <= '0;
      end else if (note_end && has_next) begin
        note <= note + 2'd1;
      end
    end
  end

  // Note fetch, duration prescaler and tone generator
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hp_q   <= '0;
      dur_q  <= '0;
      hp_cnt <= '0;
      ps_cnt <= '0;
      tk_cnt <= '0;
      tone   <= 1'b0;
    end else if (state == LOAD) begin
      hp_q   <= cur_hp;
      dur_q  <= cur_dur;
      hp_cnt <= '0;
      ps_cnt <= '0;
      tk_cnt <= '0;
      tone   <= 1'b0;
    end else if (state == PLAY) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) tk_cnt <= tk_cnt + 8'd1;
      if (hp_q != '0) begin
        if (hp_cnt == hp_q - 1'b1) begin
          hp_cnt <= '0;
          tone   <= ~tone;
        end else begin
          hp_cnt <= hp_cnt + 1'b1;
        end
      end
      if (state_n != PLAY) tone <= 1'b0;
    end
  end

  assign busy   = (state != IDLE);
  assign buzzer = tone & ~mute;

endmodule
